// File: rtl/munoc_responder_pkg.sv
// Shared definitions for the MUNOC register responder.
// Contents:
//   - link field offsets, relative to the phit width (valid/last sit above the phit)
//   - request/response header field positions
//   - responder FSM state encoding
//   - build_rsp_header: assembles the 32-bit response header
package munoc_responder_pkg;

  // Link layout is {valid, last, phit[BW_PHIT-1:0]}; offsets are added to BW_PHIT.
  localparam int LINK_LAST_OFS  = 0;
  localparam int LINK_VALID_OFS = 1;

  // Header fields (request and response share the low 16 bits).
  localparam int HDR_SRC_LSB  = 0;
  localparam int HDR_SRC_W    = 8;
  localparam int HDR_WR_BIT   = 8;
  localparam int HDR_ERR_BIT  = 9;
  localparam int HDR_LEN_LSB  = 12;
  localparam int HDR_LEN_W    = 4;
  localparam int HDR_ADDR_LSB = 16;
  localparam int HDR_RID_LSB  = 24;
  localparam int HDR_RID_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRSP  = 3'd2,
    ST_RHDR  = 3'd3,
    ST_RDATA = 3'd4
  } rsp_state_t;

  function automatic logic [31:0] build_rsp_header(
    input logic [HDR_SRC_W-1:0] dest,
    input logic                 is_write,
    input logic                 err,
    input logic [HDR_LEN_W-1:0] lenm1,
    input logic [HDR_RID_W-1:0] rid
  );
    logic [31:0] h;
    h = '0;
    h[HDR_SRC_LSB +: HDR_SRC_W] = dest;
    h[HDR_WR_BIT]               = is_write;
    h[HDR_ERR_BIT]              = err;
    h[HDR_LEN_LSB +: HDR_LEN_W] = lenm1;
    h[HDR_RID_LSB +: HDR_RID_W] = rid;
    return h;
  endfunction

endpackage

// File: rtl/munoc_reg_responder_regfile.sv
// Register file for the MUNOC register responder.
// NUM_REG words of BW_PHIT bits, one synchronous write port, one
// combinational read port, asynchronous reset to zero.
// Ports:
//   clk, rst        clock, async active-high reset
//   we/waddr/wdata  write port
//   raddr/rdata     asynchronous read port
module munoc_reg_responder_regfile #(
  parameter int BW_PHIT = 32,
  parameter int NUM_REG = 16,
  parameter int IW      = $clog2(NUM_REG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [BW_PHIT-1:0] wdata,
  input  logic [IW-1:0]      raddr,
  output logic [BW_PHIT-1:0] rdata
);

  logic [BW_PHIT-1:0] mem [NUM_REG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/munoc_network_reg_responder.sv
// MUNOC slave-end register responder.
// Consumes request packets from a forward-network router output, services
// them against an internal register file, and returns response packets on
// the backward network addressed to the requesting master.
// Ports:
//   clk, rst     clock, async active-high reset
//   rfni_link    forward link in  {valid, last, phit}
//   rfni_ready   forward link accept
//   sbni_link    backward link out {valid, last, phit}
//   sbni_ready   backward link accept
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a request header
// ST_WDATA | consuming write data phits until last
// ST_WRSP  | presenting the single-phit write response
// ST_RHDR  | presenting the read response header
// ST_RDATA | presenting read data words, last on the final one
module munoc_network_reg_responder
  import munoc_responder_pkg::*;
#(
  parameter int BW_PHIT      = 32,
  parameter int NUM_REG      = 16,
  parameter int RESPONDER_ID = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BW_PHIT+1:0] rfni_link,
  output logic               rfni_ready,
  output logic [BW_PHIT+1:0] sbni_link,
  input  logic               sbni_ready
);

  localparam int VALID_BIT = BW_PHIT + LINK_VALID_OFS;
  localparam int LAST_BIT  = BW_PHIT + LINK_LAST_OFS;
  localparam int AW        = BW_PHIT - HDR_ADDR_LSB;
  localparam int IW        = $clog2(NUM_REG);

  rsp_state_t state_q, state_d;

  logic [HDR_SRC_W-1:0] src_q, src_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic [HDR_LEN_W-1:0] lenm1_q, lenm1_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [4:0]           cnt_q, cnt_d;

  logic               in_valid, in_last, in_fire, out_fire;
  logic [BW_PHIT-1:0] in_phit;

  logic [AW-1:0]        hdr_addr;
  logic [HDR_LEN_W-1:0] hdr_lenm1;
  logic [AW:0]          hdr_end;
  logic                 hdr_range_err;

  logic [AW-1:0]      word_addr;
  logic               cnt_in_len;
  logic               rf_we;
  logic [BW_PHIT-1:0] rf_rdata;
  logic [BW_PHIT-1:0] rsp_hdr;

  logic rsp_valid, rsp_last, rsp_data_sel;

  assign in_valid = rfni_link[VALID_BIT];
  assign in_last  = rfni_link[LAST_BIT];
  assign in_phit  = rfni_link[BW_PHIT-1:0];

  assign rfni_ready = !rst && (state_q == ST_IDLE || state_q == ST_WDATA);
  assign in_fire    = in_valid && rfni_ready;
  assign out_fire   = rsp_valid && sbni_ready;

  // Range check on the last word of the burst, one bit wider than the
  // address field so an address near the top cannot wrap into valid words.
  assign hdr_addr      = in_phit[BW_PHIT-1:HDR_ADDR_LSB];
  assign hdr_lenm1     = in_phit[HDR_LEN_LSB +: HDR_LEN_W];
  assign hdr_end       = {1'b0, hdr_addr} + (AW+1)'(hdr_lenm1);
  assign hdr_range_err = hdr_end >= (AW+1)'(NUM_REG);

  assign word_addr  = addr_q + AW'(cnt_q);
  assign cnt_in_len = cnt_q <= {1'b0, lenm1_q};

  assign rsp_hdr = BW_PHIT'(build_rsp_header(src_q, wr_q, err_q, lenm1_q,
                                             HDR_RID_W'(RESPONDER_ID)));

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    wr_d         = wr_q;
    err_d        = err_q;
    lenm1_d      = lenm1_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    rf_we        = 1'b0;
    rsp_valid    = 1'b0;
    rsp_last     = 1'b0;
    rsp_data_sel = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          src_d   = in_phit[HDR_SRC_LSB +: HDR_SRC_W];
          wr_d    = in_phit[HDR_WR_BIT];
          lenm1_d = hdr_lenm1;
          addr_d  = hdr_addr;
          cnt_d   = '0;
          err_d   = hdr_range_err;
          if (in_phit[HDR_WR_BIT]) begin
            // A write header carrying last has no data at all.
            if (in_last) begin
              err_d   = 1'b1;
              state_d = ST_WRSP;
            end else begin
              state_d = ST_WDATA;
            end
          end else begin
            state_d = ST_RHDR;
          end
        end
      end

      ST_WDATA: begin
        if (in_fire) begin
          // cnt saturates at len so overlong packets are drained, not written.
          if (cnt_in_len) begin
            rf_we = !err_q;
            cnt_d = cnt_q + 5'd1;
          end else begin
            err_d = 1'b1;
          end
          if (in_last) begin
            if (cnt_q < {1'b0, lenm1_q}) err_d = 1'b1;
            state_d = ST_WRSP;
          end
        end
      end

      ST_WRSP: begin
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        if (out_fire) state_d = ST_IDLE;
      end

      ST_RHDR: begin
        rsp_valid = 1'b1;
        rsp_last  = err_q;
        if (out_fire) begin
          cnt_d   = '0;
          state_d = err_q ? ST_IDLE : ST_RDATA;
        end
      end

      ST_RDATA: begin
        rsp_valid    = 1'b1;
        rsp_data_sel = 1'b1;
        rsp_last     = (cnt_q[3:0] == lenm1_q);
        if (out_fire) begin
          cnt_d = cnt_q + 5'd1;
          if (rsp_last) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      lenm1_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      lenm1_q <= lenm1_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  munoc_reg_responder_regfile #(
    .BW_PHIT (BW_PHIT),
    .NUM_REG (NUM_REG),
    .IW      (IW)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (word_addr[IW-1:0]),
    .wdata (in_phit),
    .raddr (word_addr[IW-1:0]),
    .rdata (rf_rdata)
  );

  assign sbni_link[VALID_BIT]     = rsp_valid;
  assign sbni_link[LAST_BIT]      = rsp_last;
  assign sbni_link[BW_PHIT-1:0]   = rsp_data_sel ? rf_rdata
                                  : (rsp_valid ? rsp_hdr : '0);

  // Reserved header bits and the address bits above the register index
  // are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{in_phit[11:9], word_addr[AW-1:IW]};

endmodule

// File: tb/tb_munoc_network_reg_responder.sv
module tb_munoc_network_reg_responder;

  localparam int BW  = 32;
  localparam int NR  = 16;
  localparam int RID = 8'h5A;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW+1:0] rfni_link;
  logic          rfni_ready;
  logic [BW+1:0] sbni_link;
  logic          sbni_ready;

  always #5 clk = ~clk;

  munoc_network_reg_responder #(
    .BW_PHIT      (BW),
    .NUM_REG      (NR),
    .RESPONDER_ID (RID)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rfni_link  (rfni_link),
    .rfni_ready (rfni_ready),
    .sbni_link  (sbni_link),
    .sbni_ready (sbni_ready)
  );

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int ready_mode = 1;  // 0 random, 1 high, 2 low

  logic [BW:0]   exp_q [$];   // {last, phit}
  logic [BW-1:0] model [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_hdr(input int src, input int wr, input int err, input int lenm1);
    return BW'(src + wr * 256 + err * 512 + lenm1 * 4096 + RID * 32'h0100_0000);
  endfunction

  // Backpressure generator on the response link.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sbni_ready = ($urandom_range(0, 3) != 0);
      1:       sbni_ready = 1'b1;
      default: sbni_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted response phit and checks
  // that a stalled phit stays put until accepted.
  logic          stall_pend = 1'b0;
  logic [BW+1:0] stall_val;
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) chk("hold_stable", 64'(sbni_link), 64'(stall_val));
      if (sbni_link[BW+1] && sbni_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual=%h required=none", sbni_link);
        end else begin
          chk("rsp_phit", 64'(sbni_link[BW:0]), 64'(exp_q.pop_front()));
        end
        popped++;
        stall_pend = 1'b0;
      end else if (sbni_link[BW+1]) begin
        stall_pend = 1'b1;
        stall_val  = sbni_link;
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the phit was taken.
  task automatic send_phit(input logic last, input logic [BW-1:0] p, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      rfni_link = '0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rfni_link = {1'b1, last, p};
    do begin
      @(negedge clk);
      t++;
    end while (!rfni_ready && t < 400);
    if (!rfni_ready) begin
      checks++;
      errors++;
      $display("FAIL rfni_timeout actual=ready0 required=ready1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int src, input int addr, input int lenm1, input int ndata,
                          input bit fixed, input bit gaps);
    int len = lenm1 + 1;
    bit rerr = (addr + lenm1) >= NR;
    bit err = rerr || (ndata != len);
    logic [BW-1:0] d;
    exp_q.push_back({1'b1, exp_hdr(src, 1, int'(err), lenm1)});
    send_phit(ndata == 0,
              BW'(src + 256 + $urandom_range(0, 7) * 512 + lenm1 * 4096 + addr * 65536), gaps);
    for (int i = 0; i < ndata; i++) begin
      d = fixed ? BW'(32'hA + i) : BW'($urandom);
      if (i < len && !rerr) model[addr + i] = d;
      send_phit(i == ndata - 1, d, gaps);
    end
    rfni_link = '0;
  endtask

  task automatic do_read(input int src, input int addr, input int lenm1, input bit gaps);
    bit err = (addr + lenm1) >= NR;
    exp_q.push_back({err, exp_hdr(src, 0, int'(err), lenm1)});
    if (!err)
      for (int i = 0; i <= lenm1; i++) exp_q.push_back({i == lenm1, model[addr + i]});
    send_phit(1'b1, BW'(src + lenm1 * 4096 + addr * 65536), gaps);
    rfni_link = '0;
  endtask

  task automatic wait_popped(input int target);
    int t = 0;
    while (popped < target && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("wait_popped", 64'(popped >= target), 64'(1));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  int a, l, nd;

  initial begin
    rfni_link  = '0;
    sbni_ready = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(rfni_ready), 64'(0));
    chk("rst_sbni", 64'(sbni_link), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 64'(rfni_ready), 64'(1));
    chk("idle_sbni", 64'(sbni_link), 64'(0));

    // Basic write then read-back.
    do_write(3, 2, 1, 2, 1'b1, 1'b0);
    drain();
    do_read(5, 2, 1, 1'b0);
    drain();

    // Stall in the middle of read data.
    a = popped;
    do_read(5, 2, 1, 1'b0);
    wait_popped(a + 1);
    ready_mode = 2;
    repeat (10) @(posedge clk);
    #1;
    ready_mode = 1;
    drain();

    // Range errors, including an address that would wrap at 16 bits.
    do_read(7, 15, 1, 1'b0);
    do_read(7, 16'hFFFF, 2, 1'b0);
    do_write(8, 14, 3, 4, 1'b0, 1'b0);
    drain();

    // Short write, overlong write, header-only write, then normal traffic.
    do_write(9, 8, 3, 2, 1'b0, 1'b0);
    do_write(9, 4, 1, 4, 1'b0, 1'b0);
    do_write(9, 0, 0, 0, 1'b0, 1'b0);
    do_read(10, 0, 15, 1'b0);
    drain();

    // Randomised traffic with backpressure and source gaps.
    ready_mode = 0;
    for (int n = 0; n < 250; n++) begin
      l = $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0:       a = NR - 2 + $urandom_range(0, 4);
        1:       a = 16'hFFFF - $urandom_range(0, 3);
        default: a = $urandom_range(0, NR - 1);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        nd = ($urandom_range(0, 6) == 0) ? $urandom_range(0, l + 3) : l + 1;
        do_write($urandom_range(0, 255), a, l, nd, 1'b0, 1'b1);
      end else begin
        do_read($urandom_range(0, 255), a, l, 1'b1);
      end
    end
    ready_mode = 1;
    drain();

    // Asynchronous reset in the middle of read data.
    a = popped;
    do_read(11, 0, 3, 1'b0);
    wait_popped(a + 1);
    ready_mode = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_sbni", 64'(sbni_link), 64'(0));
    chk("async_rst_ready", 64'(rfni_ready), 64'(0));
    exp_q.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 1;
    @(posedge clk);
    #1;
    do_read(12, 0, 0, 1'b0);
    do_read(12, 2, 1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
